// File: rtl/front_panel_pkg.sv
// Shared constants and sizing helpers for the front-panel button and
// seven-segment display logic.
package front_panel_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low segments, bit0 = a ... bit6 = g; element [v] encodes hex digit v.
    localparam logic [15:0][6:0] SEG_HEX = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic int n_pages(input int data_w, input int n_digits);
        return (data_w + 4 * n_digits - 1) / (4 * n_digits);
    endfunction

    // Bits needed to index n items, never less than one.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// One push-button channel: two-flop synchronizer, stability counter,
// debounced level and single-cycle press/release pulses.
module button_debouncer
    import front_panel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int BTN_ACTIVE_LOW  = 1
) (
    input  logic clk_27,
    input  logic reset_L,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam int   CNT_W    = idx_w(DEBOUNCE_CYCLES);
    localparam logic IDLE_RAW = (BTN_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             pressed;

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        pressed = sync2_q ^ IDLE_RAW;
        cnt_d   = cnt_q;
        level_d = level_q;
        // The level flips on the edge where the count would reach DEBOUNCE_CYCLES.
        if (pressed == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            cnt_d   = '0;
            level_d = ~level_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        press_d   = level_d & ~level_q;
        release_d = ~level_d & level_q;
    end

    always_ff @(posedge clk_27) begin
        if (!reset_L) begin
            sync1_q   <= IDLE_RAW;
            sync2_q   <= IDLE_RAW;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

endmodule

// File: rtl/front_panel_io.sv
// Front-panel I/O: debounced push buttons plus a paged, registered
// hexadecimal seven-segment display with optional leading-zero blanking.
module front_panel_io
    import front_panel_pkg::*;
#(
    parameter int N_BUTTONS       = 4,
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int BTN_ACTIVE_LOW  = 1,
    parameter int N_DIGITS        = 8,
    parameter int DATA_W          = 64
) (
    input  logic                                        clk_27,
    input  logic                                        reset_L,
    input  logic [N_BUTTONS-1:0]                        btn_raw,
    output logic [N_BUTTONS-1:0]                        btn_level,
    output logic [N_BUTTONS-1:0]                        btn_press,
    output logic [N_BUTTONS-1:0]                        btn_release,
    input  logic [DATA_W-1:0]                           disp_data,
    input  logic                                        disp_valid,
    input  logic                                        freeze,
    input  logic                                        page_next,
    input  logic                                        blank_lz,
    output logic [idx_w(n_pages(DATA_W, N_DIGITS))-1:0] page,
    output logic [7*N_DIGITS-1:0]                       hex_seg_L
);

    localparam int N_PAGES   = n_pages(DATA_W, N_DIGITS);
    localparam int PAGE_W    = idx_w(N_PAGES);
    localparam int PAGE_BITS = 4 * N_DIGITS;
    localparam int PAD_W     = N_PAGES * PAGE_BITS;

    for (genvar gi = 0; gi < N_BUTTONS; gi++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
        ) u_debouncer (
            .clk_27      (clk_27),
            .reset_L     (reset_L),
            .btn_raw     (btn_raw[gi]),
            .btn_level   (btn_level[gi]),
            .btn_press   (btn_press[gi]),
            .btn_release (btn_release[gi])
        );
    end

    logic [DATA_W-1:0]     shadow_q, shadow_d;
    logic [PAGE_W-1:0]     page_q, page_d;
    logic [7*N_DIGITS-1:0] seg_q, seg_d;

    // Zero-padding to whole pages makes nibbles beyond DATA_W read as 0.
    logic [PAD_W-1:0] padded;
    logic [PAD_W-1:0] paged;
    logic [31:0]      page_shift;
    logic [3:0]       nib [N_DIGITS];

    assign padded     = PAD_W'(shadow_q);
    assign page_shift = 32'(page_q) * 32'(PAGE_BITS);
    assign paged      = padded >> page_shift;

    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_nib
        assign nib[gi] = paged[4*gi +: 4];
    end

    always_comb begin
        shadow_d = shadow_q;
        if (disp_valid && !freeze) begin
            shadow_d = disp_data;
        end
        page_d = page_q;
        if (page_next) begin
            if (N_PAGES == 1 || page_q == PAGE_W'(N_PAGES - 1)) begin
                page_d = '0;
            end else begin
                page_d = page_q + 1'b1;
            end
        end
    end

    // Scan from the top digit; blanking stops at the first nonzero digit or digit 0.
    always_comb begin
        logic lead;
        seg_d = '1;
        lead  = blank_lz;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            if (lead && k != 0 && nib[k] == 4'h0) begin
                seg_d[7*k +: 7] = SEG_BLANK;
            end else begin
                lead            = 1'b0;
                seg_d[7*k +: 7] = SEG_HEX[nib[k]];
            end
        end
    end

    always_ff @(posedge clk_27) begin
        if (!reset_L) begin
            shadow_q <= '0;
            page_q   <= '0;
            seg_q    <= '1;
        end else begin
            shadow_q <= shadow_d;
            page_q   <= page_d;
            seg_q    <= seg_d;
        end
    end

    assign page      = page_q;
    assign hex_seg_L = seg_q;

endmodule

// File: doc/front_panel_io.md
FRONT_PANEL_IO -- requirements
Module: front_panel_io

Interface
REQ-001 SHALL have parameter N_BUTTONS, default 4: number of push-button channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 65536: consecutive stable cycles required to accept a level change; minimum 2.
REQ-003 SHALL have parameter BTN_ACTIVE_LOW, default 1: raw buttons read 0 when pressed.
REQ-004 SHALL have parameter N_DIGITS, default 8: number of seven-segment digits driven.
REQ-005 SHALL have parameter DATA_W, default 64: display source width; N_PAGES = ceil(DATA_W / (4*N_DIGITS)).
REQ-006 SHALL have ports, clock and reset first:
- clk_27  in  1  sole clock, all logic on rising edge
- reset_L  in  1  synchronous, active-low reset
- btn_raw  in  N_BUTTONS  asynchronous raw buttons
- btn_level  out  N_BUTTONS  debounced state, 1 = pressed
- btn_press  out  N_BUTTONS  one-cycle pulse on debounced press
- btn_release  out  N_BUTTONS  one-cycle pulse on debounced release
- disp_data  in  DATA_W  value to display
- disp_valid  in  1  load strobe for disp_data
- freeze  in  1  1 = ignore disp_valid, hold shadow
- page_next  in  1  advance displayed page, one pulse = one step
- blank_lz  in  1  1 = blank leading zero digits
- page  out  clog2(N_PAGES), min 1  current page index
- hex_seg_L  out  7*N_DIGITS  active-low segments; digit k at bits [7k+6:7k], bit0 = a, bit6 = g
REQ-007 One clock; reset is synchronous and active-low, named reset_L.

Function
REQ-008 Each btn_raw bit SHALL pass through a 2-flop synchronizer, then be inverted if BTN_ACTIVE_LOW = 1.
REQ-009 Per channel, synced value != btn_level SHALL increment a counter; equality SHALL clear it.
REQ-010 btn_level SHALL toggle, and its counter clear, on the edge where the counter would reach DEBOUNCE_CYCLES; total latency = 2 + DEBOUNCE_CYCLES cycles after a clean raw change.
REQ-011 A glitch shorter than DEBOUNCE_CYCLES synced cycles SHALL NOT change btn_level.
REQ-012 btn_press SHALL be high exactly in the first cycle btn_level reads 1; btn_release exactly in the first cycle it reads 0.
REQ-013 disp_valid = 1 with freeze = 0 SHALL load disp_data into a DATA_W shadow register; with freeze = 1 it SHALL be ignored.
REQ-014 page_next = 1 SHALL increment page, wrapping N_PAGES-1 -> 0; when N_PAGES = 1, page SHALL stay 0.
REQ-015 Simultaneous disp_valid and page_next SHALL both take effect in the same cycle.
REQ-016 Digit k SHALL show nibble shadow[page*4*N_DIGITS + 4k +: 4]; bits at or above DATA_W SHALL read 0.
REQ-017 Encoding SHALL be standard active-low hex: 0=7'h40, 1=7'h79, 8=7'h00, A=7'h08, F=7'h0E.
REQ-018 With blank_lz = 1, zero digits from the most significant digit down to the first nonzero digit SHALL be 7'h7F; digit 0 SHALL never blank.
REQ-019 hex_seg_L SHALL be registered: segments reflect shadow, page and blank_lz one cycle after they change, so disp_valid -> segments takes 2 cycles.

Reset
REQ-020 While reset_L = 0 at an edge: synchronizers 0 (not pressed), counters 0, btn_level, btn_press and btn_release 0, shadow 0, page 0, hex_seg_L all ones.
REQ-021 Reset mid-debounce SHALL discard progress; a button held through reset SHALL need a full debounce and SHALL then generate btn_press.

Structure
REQ-022 Shared package front_panel_pkg SHALL hold the segment constants (SEG_BLANK and 0-F table) and the page-count and width helper functions.
REQ-023 A per-channel sub-module button_debouncer (synchronizer, counter, level, press/release) SHALL be instantiated N_BUTTONS times via generate.

Verification
REQ-024 The bench SHALL use DEBOUNCE_CYCLES = 4 and cover:
- Reset: reset_L = 0 for 2 cycles -> btn_level = 0, page = 0, every digit 7'h7F; the next cycle every digit is 7'h40.
- Debounce: btn_raw[0] held 0 -> btn_level[0] rises exactly 6 cycles later, btn_press[0] is high for 1 cycle, and btn_release[0] follows 6 cycles after release.
- Glitch: btn_raw[1] low for 3 synced cycles -> no btn_level or btn_press change.
- Load/freeze: disp_data = 64'h0000_0000_DEAD_BEEF, disp_valid -> 2 cycles later digits are D,E,A,D,B,E,E,F; with freeze = 1, loading 64'h1 -> display unchanged.
- Paging: page_next twice -> page 0 -> 1 -> 0; page 1 of 64'h1234_5678_0000_0000 shows 12345678; page_next and disp_valid in the same cycle -> both applied.
- Blanking: blank_lz = 1 with shadow 64'h0000_0000_0000_00A0 -> digits 7..2 = 7'h7F, digit 1 = 7'h08, digit 0 = 7'h40; with shadow 0 only digit 0 is lit.
